ref_gray_to_bin_sync: RTL
=========================

Name: ref_gray_to_bin_sync

Overview:
Receive-side counterpart of the team's binary-to-Gray encoder. Accepts a Gray-coded counter or pointer launched from a foreign clock domain and synchronizes it through a flop chain. Decodes it to binary with a registered output. Tracks the per-cycle increment and flags illegal forward jumps. Sits on the read/write-pointer crossing of the async FIFOs and DMA descriptor counters.

Parameters:
WIDTH, 7, bit width of the Gray input and binary output.
SYNC_STAGES, 2, synchronizer flop count; legal range 2..4.
MAX_STEP, 4, largest legal modular increment between consecutive decoded samples.

Ports:
clk  input  1  single clock for the whole block.
rst  input  1  synchronous, active-high reset.
gray_in  input  WIDTH  Gray-coded value from the foreign domain; asynchronous to clk.
err_clr  input  1  pulse that clears the sticky jump_err.
q  output  WIDTH  decoded binary value, registered.
q_vld  output  1  q reflects a post-reset synchronized sample.
delta  output  WIDTH  (q_new - q_old) mod 2^WIDTH, registered and aligned with q.
delta_vld  output  1  delta is meaningful.
jump_err  output  1  sticky; an increment greater than MAX_STEP was seen.

Behaviour:
- Reset (rst=1 at a clk edge): all sync flops, q, delta, fill counter, q_vld, delta_vld and jump_err go to 0. Reset mid-operation discards the pipeline immediately, and the fill sequence restarts.
- Sync chain: sync[0] <= gray_in, and sync[i] <= sync[i-1] on every edge. No logic is allowed between sync flops.
- Decode (combinational from sync[SYNC_STAGES-1]):
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0
- On each edge: q <= b, and delta <= (b - q) truncated to WIDTH bits, which gives natural wrap.
- Latency: gray_in stable before edge k appears on q after edge k+SYNC_STAGES (SYNC_STAGES+1 edges total; 3 by default).
- Fill counter: 3-bit saturating counter, incremented each edge while rst=0.
  - q_vld rises at the (SYNC_STAGES+1)th edge after reset release.
  - delta_vld rises one edge later.
  - Both remain 1 until the next reset.
- jump_err (priority set > clear > hold):
  - Set on an edge where delta_vld=1 and delta > MAX_STEP, evaluated on the registered delta.
  - Otherwise cleared by err_clr=1.
  - Otherwise holds.
  - Simultaneous set and err_clr leaves it at 1.
- Backward steps alias to large deltas (e.g. -1 gives 2^WIDTH-1) and therefore set jump_err.
- delta = 0 is legal: a stalled source is not an error.
- Wrap-around is legal: 2^WIDTH-1 to 0 gives delta = 1.
- Before q_vld, q and delta are 0. Consumers must gate on q_vld / delta_vld.
- Source counter is required to reset to 0 with Gray code 0. The first delta is computed against 0.
- Only this block's sync flops carry the ASYNC_REG attribute.

Test Plan:
1. Reset release with gray_in=0.
   - q_vld=0 for edges 1..2, q_vld=1 at edge 3, delta_vld=1 at edge 4.
   - q=0, delta=0, jump_err=0 throughout.
2. Latency: drive gray_in=7 (binary 5) one cycle before edge k.
   - q=5 and delta=5 after edge k+2.
   - jump_err sets at edge k+3 (5 > 4).
3. Monotonic walk: gray_in stepped through binary 0..127..3, one count per 2 cycles, Gray-encoded.
   - q follows with 3-edge lag.
   - delta in {0,1}, including the 127 -> 0 wrap.
   - jump_err stays 0.
4. Wrap jump: q=127 (gray 64), then gray_in=3 (binary 2).
   - delta=3, no error.
   - Then gray_in=30 (binary 20): delta=18, jump_err=1.
   - err_clr pulsed the same cycle as the set: jump_err stays 1.
   - err_clr pulsed next cycle: jump_err returns to 0.
5. Backward step: q=10 (gray 15), then gray_in=13 (binary 9).
   - delta=127 and jump_err=1.
6. Mid-run reset: assert rst for 1 cycle while q=20.
   - q, delta, q_vld, delta_vld and jump_err read 0 the edge after.
   - The fill sequence from test 1 repeats.

Source files
------------

// File: rtl/ref_gray_to_bin_sync_if.sv
// Gray-to-binary receive bundle: foreign-domain Gray value in,
// decoded binary, increment and jump flag out.
interface ref_gray_to_bin_sync_if #(
   parameter int WIDTH = 7
);
   logic [WIDTH-1:0] gray_in;
   logic             err_clr;
   logic [WIDTH-1:0] q;
   logic             q_vld;
   logic [WIDTH-1:0] delta;
   logic             delta_vld;
   logic             jump_err;

   modport master (
      output gray_in,
      output err_clr,
      input  q,
      input  q_vld,
      input  delta,
      input  delta_vld,
      input  jump_err
   );

   modport slave (
      input  gray_in,
      input  err_clr,
      output q,
      output q_vld,
      output delta,
      output delta_vld,
      output jump_err
   );
endinterface

// File: rtl/ref_gray_to_bin_sync.sv
// Synchronizes a foreign Gray counter, decodes it to binary and
// tracks the per-cycle increment, flagging jumps above MAX_STEP.
module ref_gray_to_bin_sync #(
   parameter int WIDTH       = 7,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_STEP    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   ref_gray_to_bin_sync_if.slave bus
);
   localparam logic [2:0] QV_AT = 3'(SYNC_STAGES);
   localparam logic [2:0] DV_AT = 3'(SYNC_STAGES + 1);
   localparam logic [WIDTH-1:0] MAX_D = WIDTH'(MAX_STEP);

   (* ASYNC_REG = "TRUE" *)
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] delta_q, delta_d;
   logic [2:0]       fill_q, fill_d;
   logic             q_vld_q, q_vld_d;
   logic             delta_vld_q, delta_vld_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] g;

   assign g = sync_q[SYNC_STAGES-1];

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      q_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         q_d[i] = ^(g >> i);
      end
   end

   always_comb begin
      delta_d     = q_d - q_q;
      fill_d      = (fill_q == 3'd7) ? fill_q : fill_q + 3'd1;
      q_vld_d     = q_vld_q | (fill_q >= QV_AT);
      delta_vld_d = delta_vld_q | (fill_q >= DV_AT);
      err_d       = err_q;
      if (delta_vld_q && (delta_q > MAX_D)) begin
         err_d = 1'b1;
      end else if (bus.err_clr) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q         <= '0;
         delta_q     <= '0;
         fill_q      <= '0;
         q_vld_q     <= 1'b0;
         delta_vld_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         q_q         <= q_d;
         delta_q     <= delta_d;
         fill_q      <= fill_d;
         q_vld_q     <= q_vld_d;
         delta_vld_q <= delta_vld_d;
         err_q       <= err_d;
      end
   end

   assign bus.q         = q_q;
   assign bus.q_vld     = q_vld_q;
   assign bus.delta     = delta_q;
   assign bus.delta_vld = delta_vld_q;
   assign bus.jump_err  = err_q;
endmodule
